// File: rtl/uart_tx_sched_if.sv
// Producer-side valid/ready bus and uart_tx control lines for the shared serializer scheduler.
interface uart_tx_sched_if #(
  parameter int N_REQ = 4
) ();
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;
  logic               tx_dv;
  logic [7:0]         tx_byte;
  logic               tx_active;
  logic               tx_done;

  modport slave (
    input  req_valid, req_data, tx_active, tx_done,
    output req_ready, tx_dv, tx_byte
  );

  modport master (
    output req_valid, req_data, tx_active, tx_done,
    input  req_ready, tx_dv, tx_byte
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx among N_REQ byte producers.
// Every output is registered; winner selection and next-state logic are combinational.
module uart_tx_sched #(
  parameter int N_REQ        = 4,
  parameter int CLKS_PER_BIT = 87,
  parameter int TIMEOUT_CLKS = 1024,
  parameter int GAP_CLKS     = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  uart_tx_sched_if.slave           bus,
  output logic [$clog2(N_REQ)-1:0] grant_id_o,
  output logic                     busy_o,
  output logic                     timeout_err_o
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT_CLKS);
  localparam int GW = (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CLKS - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
    $error("uart_tx_sched: N_REQ must be in 2..8");
  end
  if (TIMEOUT_CLKS <= 10 * CLKS_PER_BIT) begin : g_bad_timeout
    $error("uart_tx_sched: TIMEOUT_CLKS must exceed one frame time");
  end

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d, grant_q, grant_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [GW-1:0]    gap_q, gap_d;
  logic [N_REQ-1:0] ready_q, ready_d;
  logic             dv_q, dv_d, busy_q, busy_d, terr_q, terr_d;
  logic [7:0]       byte_q, byte_d, win_byte;
  logic [IW-1:0]    win, ptr_nxt;
  logic             found;

  // Winner: first valid index at or above ptr, otherwise the lowest valid index (wrap-around).
  always_comb begin
    found    = 1'b0;
    win      = '0;
    win_byte = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && bus.req_valid[j] && (IW'(j) >= ptr_q)) begin
        found    = 1'b1;
        win      = IW'(j);
        win_byte = bus.req_data[8*j +: 8];
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && bus.req_valid[j]) begin
        found    = 1'b1;
        win      = IW'(j);
        win_byte = bus.req_data[8*j +: 8];
      end
    end
    ptr_nxt = (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
    cnt_inc = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      ready_q <= '0;
      dv_q    <= 1'b0;
      byte_q  <= '0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      ready_q <= ready_d;
      dv_q    <= dv_d;
      byte_q  <= byte_d;
      busy_q  <= busy_d;
      terr_q  <= terr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (!bus.tx_active && found) state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.tx_done)             state_d = (GAP_CLKS == 0) ? S_IDLE : S_GAP;
        else if (cnt_inc == TO_LAST) state_d = S_IDLE;
      end
      S_GAP:    if (gap_q == GAP_LAST) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are computed for the next cycle, so ready/dv are high exactly while in LAUNCH
  // and timeout_err lands TIMEOUT_CLKS cycles after LAUNCH, together with the return to IDLE.
  always_comb begin
    ready_d = '0;
    dv_d    = 1'b0;
    terr_d  = 1'b0;
    byte_d  = byte_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    busy_d  = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (state_d == S_LAUNCH) begin
          byte_d       = win_byte;
          grant_d      = win;
          ptr_d        = ptr_nxt;
          ready_d[win] = 1'b1;
          dv_d         = 1'b1;
        end
      end
      S_LAUNCH: cnt_d = '0;
      S_WAIT: begin
        cnt_d = cnt_inc;
        gap_d = '0;
        if (!bus.tx_done && (cnt_inc == TO_LAST)) terr_d = 1'b1;
      end
      S_GAP:   if (gap_q != GAP_LAST) gap_d = gap_q + 1'b1;
      default: ;
    endcase
  end

  assign bus.req_ready = ready_q;
  assign bus.tx_dv     = dv_q;
  assign bus.tx_byte   = byte_q;
  assign grant_id_o    = grant_q;
  assign busy_o        = busy_q;
  assign timeout_err_o = terr_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a behavioural uart_tx model and serial-line decoder.
module tb_uart_tx_sched;
  localparam int N_REQ = 4;
  localparam int CPB   = 4;
  localparam int TO    = 64;
  localparam int GAP   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] grant_id;
  logic       busy, timeout_err;

  uart_tx_sched_if #(.N_REQ(N_REQ)) bus ();

  uart_tx_sched #(
    .N_REQ(N_REQ), .CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO), .GAP_CLKS(GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .grant_id_o(grant_id), .busy_o(busy), .timeout_err_o(timeout_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // uart_tx model: reacts to tx_dv one cycle later, 10 bits of CPB clocks, then a tx_done pulse.
  int         cyc = 0;
  int         inj_at = -1;
  int         u_pos = 0;
  int         last_done = 0;
  bit         uart_en = 1'b1;
  bit         u_busy = 1'b0;
  logic [9:0] u_frame = '1;
  logic [9:0] dec_sh = '0;
  logic       line = 1'b1;
  logic [7:0] dec_q[$];

  initial begin
    bus.tx_active = 1'b0;
    bus.tx_done   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      bus.tx_done = (cyc == inj_at);
      if (u_busy) begin
        u_pos++;
        if (u_pos >= 10 * CPB) begin
          u_busy        = 1'b0;
          bus.tx_active = 1'b0;
          bus.tx_done   = 1'b1;
          line          = 1'b1;
          last_done     = cyc;
          dec_q.push_back(dec_sh[8:1]);
        end else begin
          if (u_pos % CPB == 0) u_frame = u_frame >> 1;
          line = u_frame[0];
          if (u_pos % CPB == CPB / 2) dec_sh = {line, dec_sh[9:1]};
        end
      end else if (uart_en && bus.tx_dv) begin
        u_busy        = 1'b1;
        u_pos         = 0;
        u_frame       = {1'b1, bus.tx_byte, 1'b0};
        line          = 1'b0;
        bus.tx_active = 1'b1;
      end
    end
  end

  task automatic wait_dv(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (bus.tx_dv) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_frames(input int target, input string tag);
    for (int i = 0; i < 200; i++) begin
      if (dec_q.size() >= target) break;
      @(negedge clk);
    end
    chk_eq(tag, dec_q.size(), target);
    repeat (GAP + 2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int         n;
    int         base;
    logic [1:0] exp_g[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0] exp_r;
    logic [7:0] exp_b;
    bit         seen_busy, seen_ready;

    bus.req_valid = '0;
    bus.req_data  = '0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk_eq("rst_ready", bus.req_ready, 0);
    chk_eq("rst_dv", bus.tx_dv, 0);
    chk_eq("rst_byte", bus.tx_byte, 0);
    chk_eq("rst_grant", grant_id, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_terr", timeout_err, 0);
    rst_n = 1'b1;

    // Requester 2 alone
    @(negedge clk);
    bus.req_data  = 32'h00AA_0000;
    bus.req_valid = 4'b0100;
    wait_dv(10, n);
    chk_eq("t1_latency", n, 1);
    chk_eq("t1_byte", bus.tx_byte, 8'hAA);
    chk_eq("t1_ready", bus.req_ready, 4'b0100);
    chk_eq("t1_grant", grant_id, 2);
    chk_eq("t1_busy", busy, 1);
    bus.req_valid = '0;
    @(negedge clk);
    chk_eq("t1_dv_pulse", bus.tx_dv, 0);
    chk_eq("t1_ready_pulse", bus.req_ready, 0);
    wait_frames(1, "t1_frames");
    chk_eq("t1_decode", dec_q[0], 8'hAA);
    chk_eq("t1_idle", busy, 0);

    // All four held valid from ptr=0
    do_reset();
    bus.req_data  = 32'h4332_2110;
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_dv(120, n);
      exp_r = 4'b0001 << exp_g[i];
      exp_b = 8'h10 + 8'h11 * exp_g[i];
      chk_eq("t2_dv_seen", (n > 0), 1);
      chk_eq("t2_grant", grant_id, exp_g[i]);
      chk_eq("t2_byte", bus.tx_byte, exp_b);
      chk_eq("t2_ready", bus.req_ready, exp_r);
      if (i > 0) chk_eq("t2_gap", cyc - last_done, GAP + 2);
    end
    bus.req_valid = '0;
    wait_frames(6, "t2_frames");
    for (int i = 0; i < 5; i++) begin
      exp_b = 8'h10 + 8'h11 * exp_g[i];
      chk_eq("t2_decode", dec_q[1 + i], exp_b);
    end

    // Requesters 1 and 3 with ptr=2
    do_reset();
    base          = dec_q.size();
    bus.req_data  = 32'hC300_B100;
    bus.req_valid = 4'b0010;
    wait_dv(10, n);
    chk_eq("t3_setup_grant", grant_id, 1);
    bus.req_valid = '0;
    wait_frames(base + 1, "t3_setup_frame");
    bus.req_valid = 4'b1010;
    wait_dv(10, n);
    chk_eq("t3_first_grant", grant_id, 3);
    chk_eq("t3_first_byte", bus.tx_byte, 8'hC3);
    bus.req_valid = 4'b0010;
    wait_dv(120, n);
    chk_eq("t3_second_grant", grant_id, 1);
    chk_eq("t3_second_byte", bus.tx_byte, 8'hB1);
    bus.req_valid = '0;
    wait_frames(base + 3, "t3_frames");

    // tx_done never arrives -> timeout, then pointer has moved past requester 0
    uart_en       = 1'b0;
    bus.req_data  = 32'h0000_6677;
    bus.req_valid = 4'b0001;
    wait_dv(10, n);
    chk_eq("t4_grant", grant_id, 0);
    bus.req_valid = '0;
    n = -1;
    for (int i = 1; i <= TO + 20; i++) begin
      @(negedge clk);
      if (timeout_err) begin
        n = i;
        break;
      end
    end
    chk_eq("t4_timeout_at", n, TO);
    chk_eq("t4_busy_low", busy, 0);
    @(negedge clk);
    chk_eq("t4_pulse_width", timeout_err, 0);
    uart_en       = 1'b1;
    bus.req_valid = 4'b0011;
    wait_dv(10, n);
    chk_eq("t4_next_served", n, 1);
    chk_eq("t4_next_grant", grant_id, 1);
    chk_eq("t4_next_byte", bus.tx_byte, 8'h66);
    bus.req_valid = '0;
    base = dec_q.size();
    wait_frames(base + 1, "t4_frame");

    // Stray tx_done while idle
    inj_at     = cyc + 2;
    seen_busy  = 1'b0;
    seen_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen_busy  |= busy;
      seen_ready |= (|bus.req_ready) | bus.tx_dv;
    end
    chk_eq("t6_busy", seen_busy, 0);
    chk_eq("t6_ready", seen_ready, 0);
    chk_eq("t6_grant_kept", grant_id, 1);

    // Reset in the middle of frame bit 4, request still pending
    base          = dec_q.size();
    bus.req_data  = 32'h005A_0000;
    bus.req_valid = 4'b0100;
    wait_dv(10, n);
    chk_eq("t5_grant", grant_id, 2);
    bus.req_data = 32'h003C_0000;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (u_busy && (u_pos >= 4 * CPB)) break;
    end
    #1 rst_n = 1'b0;
    #1;
    chk_eq("t5_rst_busy", busy, 0);
    chk_eq("t5_rst_byte", bus.tx_byte, 0);
    chk_eq("t5_rst_grant", grant_id, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_dv(100, n);
    chk_eq("t5_dv_seen", (n > 0), 1);
    chk_eq("t5_launch_after_done", cyc - last_done, 1);
    chk_eq("t5_byte", bus.tx_byte, 8'h3C);
    chk_eq("t5_new_grant", grant_id, 2);
    bus.req_valid = '0;
    wait_frames(base + 2, "t5_frames");
    chk_eq("t5_decode_old", dec_q[base], 8'h5A);
    chk_eq("t5_decode_new", dec_q[base + 1], 8'h3C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end
endmodule
